// File: rtl/pack_arbiter.sv
// -----------------------------------------------------------------------------
// pack_arbiter
//
// Shares one bit packer (byte in, serial bit out with preamble) between
// NUM_SRC byte-stream sources. One source is granted per packet in round-robin
// order; exactly LENGTH_BYTE bytes are pushed into the packer (zero-padded if
// the source drops its request mid-packet), and the grant is held until the
// packer has emitted all LENGTH_SER serial beats of that packet.
//
// Ports
//   i_clk         clock, rising edge
//   i_reset       asynchronous reset, active low
//   i_req         per-source request (level)
//   i_data        per-source byte, source k at [k*SIZE_INPUT_BIT +: SIZE_INPUT_BIT]
//   i_valid       per-source byte valid
//   o_src_ready   per-source byte-accepted strobe
//   o_grant       one-hot grant, zero while idle
//   o_pack_data   byte to the packer
//   o_pack_valid  byte valid to the packer
//   i_pack_ready  packer ready for a byte
//   i_ser_valid   packer serial valid (monitored)
//   i_ser_ready   downstream serial ready (monitored)
//   o_done        one-cycle pulse on the last serial beat of a packet
//   o_pad         one-cycle pulse when the packet switches to zero padding
// -----------------------------------------------------------------------------
module pack_arbiter #(
    parameter int NUM_SRC        = 2,
    parameter int SIZE_INPUT_BIT = 8,
    parameter int SIZE_BIT_PACK  = 1976,
    parameter int SIZE_PREAMBLE  = 32,
    parameter int LENGTH_BYTE    = SIZE_BIT_PACK / SIZE_INPUT_BIT,
    parameter int LENGTH_SER     = SIZE_BIT_PACK + SIZE_PREAMBLE
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic [NUM_SRC-1:0]                i_req,
    input  logic [NUM_SRC*SIZE_INPUT_BIT-1:0] i_data,
    input  logic [NUM_SRC-1:0]                i_valid,
    output logic [NUM_SRC-1:0]                o_src_ready,
    output logic [NUM_SRC-1:0]                o_grant,
    output logic [SIZE_INPUT_BIT-1:0]         o_pack_data,
    output logic                              o_pack_valid,
    input  logic                              i_pack_ready,
    input  logic                              i_ser_valid,
    input  logic                              i_ser_ready,
    output logic                              o_done,
    output logic                              o_pad
);

    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int BYTE_W = $clog2(LENGTH_BYTE + 1);
    localparam int SER_W  = $clog2(LENGTH_SER + 1);

    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(LENGTH_BYTE - 1);
    localparam logic [SER_W-1:0]  SER_LAST  = SER_W'(LENGTH_SER - 1);
    localparam logic [SER_W-1:0]  SER_FULL  = SER_W'(LENGTH_SER);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(NUM_SRC - 1);
    localparam logic [IDX_W:0]    NUM_SRC_X = (IDX_W+1)'(NUM_SRC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [SER_W-1:0]    ser_cnt_q, ser_cnt_d;

    // Round-robin pick: first requester at or after ptr_q, wrapping.
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W:0]      cand_sum;

    // NOTE: every variable driven from always_comb gets a default at the top of
    // the block so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand_sum   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand_sum >= NUM_SRC_X) begin
                cand_sum = cand_sum - NUM_SRC_X;
            end
            if (!pick_found && i_req[cand_sum[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand_sum[IDX_W-1:0];
            end
        end
    end

    // Signals of the granted source.
    logic [NUM_SRC-1:0]        grant_vec;
    logic [SIZE_INPUT_BIT-1:0] sel_data;
    logic                      sel_valid;
    logic                      sel_req;

    always_comb begin
        grant_vec = '0;
        sel_data  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (gidx_q == IDX_W'(k)) begin
                grant_vec[k] = 1'b1;
                sel_data     = i_data[k*SIZE_INPUT_BIT +: SIZE_INPUT_BIT];
            end
        end
        sel_valid = i_valid[gidx_q];
        sel_req   = i_req[gidx_q];
    end

    logic ser_beat;
    logic load_beat;

    assign ser_beat  = i_ser_valid & i_ser_ready;
    assign load_beat = sel_valid & i_pack_ready;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gidx_d       = gidx_q;
        byte_cnt_d   = byte_cnt_q;
        ser_cnt_d    = ser_cnt_q;
        o_grant      = '0;
        o_src_ready  = '0;
        o_pack_data  = '0;
        o_pack_valid = 1'b0;
        o_done       = 1'b0;
        o_pad        = 1'b0;

        // The packer may already be emitting serial beats while bytes are
        // still being loaded, so beats are counted in every busy state. The
        // count saturates at a full packet; it is cleared only at grant.
        if (state_q != S_IDLE && ser_beat && ser_cnt_q != SER_FULL) begin
            ser_cnt_d = ser_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gidx_d     = pick_idx;
                    byte_cnt_d = '0;
                    ser_cnt_d  = '0;
                    state_d    = S_LOAD;
                end
            end

            S_LOAD: begin
                o_grant      = grant_vec;
                o_pack_data  = sel_data;
                o_pack_valid = sel_valid;
                o_src_ready  = grant_vec & {NUM_SRC{load_beat}};
                if (load_beat) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
                if (load_beat && byte_cnt_q == BYTE_LAST) begin
                    state_d = S_DRAIN;
                end else if (!sel_req) begin
                    // A byte offered in the same cycle as the drop is still
                    // consumed above; padding covers the remainder.
                    state_d = S_PAD;
                    o_pad   = 1'b1;
                end
            end

            S_PAD: begin
                o_grant      = grant_vec;
                o_pack_valid = 1'b1;
                if (i_pack_ready) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == BYTE_LAST) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                o_grant = grant_vec;
                if (ser_cnt_q == SER_FULL || (ser_beat && ser_cnt_q == SER_LAST)) begin
                    o_done  = 1'b1;
                    ptr_d   = (gidx_q == IDX_MAX) ? '0 : gidx_q + 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before the clock edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            byte_cnt_q <= '0;
            ser_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            byte_cnt_q <= byte_cnt_d;
            ser_cnt_q  <= ser_cnt_d;
        end
    end

endmodule

// File: tb/tb_pack_arbiter.sv
module tb_pack_arbiter;

    localparam int N      = 2;
    localparam int W      = 8;
    localparam int LB     = 247;
    localparam int LS     = 2008;
    localparam int BUDGET = 10000;

    logic             i_clk;
    logic             i_reset;
    logic [N-1:0]     i_req;
    logic [N*W-1:0]   i_data;
    logic [N-1:0]     i_valid;
    logic [N-1:0]     o_src_ready;
    logic [N-1:0]     o_grant;
    logic [W-1:0]     o_pack_data;
    logic             o_pack_valid;
    logic             i_pack_ready;
    logic             i_ser_valid;
    logic             i_ser_ready;
    logic             o_done;
    logic             o_pad;

    pack_arbiter #(.NUM_SRC(N)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req        (i_req),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_src_ready  (o_src_ready),
        .o_grant      (o_grant),
        .o_pack_data  (o_pack_data),
        .o_pack_valid (o_pack_valid),
        .i_pack_ready (i_pack_ready),
        .i_ser_valid  (i_ser_valid),
        .i_ser_ready  (i_ser_ready),
        .o_done       (o_done),
        .o_pad        (o_pad)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want_v);
        n_total++;
        assert (obs === want_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want_v);
        end
    endtask

    // ---------------- reference model / source behaviour ----------------
    bit         want[N];          // source wishes to send a packet
    int         abandon_after[N]; // source drops request after this many bytes
    bit         const_mode[N];
    logic [7:0] const_val[N];
    int         sent[N];          // bytes accepted from source in current packet
    logic [7:0] seq[N][LB];       // bytes the source will offer, in order
    int         stall_src, stall_at, stall_left;
    bit         bp, ser_toggle;
    int         cyc = 0;

    logic [7:0] pack_log[$];      // bytes the packer accepted this packet
    int         grant_hist[$];    // observed granted source per packet
    int         ser_beats, pad_cnt, packets_left;
    int         ptr_model, cur_src;
    bit         in_packet, had_req_prev;
    logic [N-1:0] prev_req;

    task automatic regen(input int k);
        for (int i = 0; i < LB; i++)
            seq[k][i] = const_mode[k] ? const_val[k] : 8'($urandom_range(0, 255));
    endtask

    function automatic int rr_pick(input logic [N-1:0] req);
        for (int off = 0; off < N; off++)
            if (req[(ptr_model + off) % N]) return (ptr_model + off) % N;
        return -1;
    endfunction

    task automatic model_reset();
        in_packet    = 1'b0;
        had_req_prev = 1'b0;
        pack_log.delete();
        ptr_model    = 0;
        ser_beats    = 0;
        pad_cnt      = 0;
        stall_left   = 0;
        for (int k = 0; k < N; k++) sent[k] = 0;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            bit r, st;
            r  = want[k] && (sent[k] < abandon_after[k]);
            st = (k == stall_src) && (stall_left > 0) && (sent[k] == stall_at);
            i_req[k]   = r;
            i_valid[k] = r && !st;
            i_data[k*W +: W] = (r && !st && sent[k] < LB) ? seq[k][sent[k]] : 8'h00;
            if (st && in_packet && cur_src == k) stall_left--;
        end
        i_pack_ready = bp ? (cyc % 3 != 2) : 1'b1;
        i_ser_valid  = in_packet && (pack_log.size() >= LB);
        i_ser_ready  = ser_toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
    endtask

    task automatic finish_packet();
        int n_real, mism;
        logic [7:0] e;
        check("done_in_packet", in_packet, 1);
        check("ser_beats_at_done", ser_beats, LS);
        check("pkt_len", pack_log.size(), LB);
        n_real = (abandon_after[cur_src] < LB) ? abandon_after[cur_src] : LB;
        mism = 0;
        for (int i = 0; i < pack_log.size(); i++) begin
            e = (i < n_real) ? seq[cur_src][i] : 8'h00;
            if (pack_log[i] !== e) mism++;
        end
        check("pkt_bytes_wrong", mism, 0);
        check("src_accepted", sent[cur_src], n_real);
        check("pad_pulses", pad_cnt, (n_real < LB) ? 1 : 0);
        ptr_model = (cur_src + 1) % N;
        in_packet = 1'b0;
        sent[cur_src] = 0;
        regen(cur_src);
        pack_log.delete();
        packets_left--;
        if (packets_left <= 0)
            for (int k = 0; k < N; k++) want[k] = 1'b0;
    endtask

    task automatic monitor();
        logic [N-1:0] g_exp;
        int obs_src;
        if (!i_reset) begin
            had_req_prev = 1'b0;
            return;
        end
        check("grant_onehot0", 32'($onehot0(o_grant)), 1);
        check("rdy_without_pack_ready", o_src_ready & ~{N{i_pack_ready}}, 0);
        check("rdy_outside_grant", o_src_ready & ~o_grant, 0);
        obs_src = -1;
        for (int k = 0; k < N; k++) if (o_grant[k]) obs_src = k;
        if (had_req_prev) begin
            g_exp = '0;
            g_exp[rr_pick(prev_req)] = 1'b1;
            check("grant", o_grant, g_exp);
            check("grant_while_busy", in_packet, 0);
            in_packet = 1'b1;
            cur_src   = rr_pick(prev_req);
            grant_hist.push_back(obs_src);
            pad_cnt   = 0;
            ser_beats = 0;
            pack_log.delete();
        end else if (in_packet) begin
            g_exp = '0;
            g_exp[cur_src] = 1'b1;
            check("grant_hold", o_grant, g_exp);
        end
        had_req_prev = (o_grant == '0) && (i_req != '0);
        prev_req     = i_req;
        if (o_pack_valid && i_pack_ready) pack_log.push_back(o_pack_data);
        for (int k = 0; k < N; k++) if (o_src_ready[k]) sent[k]++;
        if (in_packet && i_ser_valid && i_ser_ready) ser_beats++;
        if (o_pad) pad_cnt++;
        if (o_done) finish_packet();
    endtask

    task automatic tick();
        drive();
        @(negedge i_clk);
        monitor();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        for (int k = 0; k < N; k++) want[k] = 1'b0;
        i_reset = 1'b0;
        model_reset();
        repeat (3) tick();
        i_reset = 1'b1;
    endtask

    task automatic wait_packets(input int n);
        packets_left = n;
        for (int c = 0; c < n * BUDGET; c++) begin
            tick();
            if (packets_left <= 0) break;
        end
        check("packets_remaining", packets_left, 0);
        if (packets_left > 0) do_reset();
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_grant"}, o_grant, 0);
        check({pfx, "_src_ready"}, o_src_ready, 0);
        check({pfx, "_pack_valid"}, o_pack_valid, 0);
        check({pfx, "_pack_data"}, o_pack_data, 0);
        check({pfx, "_done"}, o_done, 0);
        check({pfx, "_pad"}, o_pad, 0);
    endtask

    initial begin
        i_reset = 1'b0;
        i_req = '0; i_valid = '0; i_data = '0;
        i_pack_ready = 1'b0; i_ser_valid = 1'b0; i_ser_ready = 1'b0;
        bp = 1'b0; ser_toggle = 1'b0; stall_src = 0; stall_at = 0;
        for (int k = 0; k < N; k++) begin
            want[k] = 1'b0; abandon_after[k] = LB; const_mode[k] = 1'b0;
            const_val[k] = 8'h00; regen(k);
        end
        model_reset();

        // Reset state.
        repeat (3) @(posedge i_clk);
        #1;
        check_outputs_zero("rst");
        i_reset = 1'b1;
        tick(); tick();
        check_outputs_zero("post_rst");

        // Single source, constant 0x41, serial ready toggling.
        const_mode[0] = 1'b1; const_val[0] = 8'h41; regen(0);
        ser_toggle = 1'b1;
        grant_hist.delete();
        want[0] = 1'b1;
        wait_packets(1);
        check("single_src", (grant_hist.size() > 0) ? grant_hist[0] : -1, 0);
        tick(); tick();
        check("idle_grant", o_grant, 0);
        check("idle_pack_valid", o_pack_valid, 0);
        const_mode[0] = 1'b0; regen(0);
        ser_toggle = 1'b0;

        // Contention from a fresh pointer: src0, src1, src0.
        do_reset();
        grant_hist.delete();
        want[0] = 1'b1; want[1] = 1'b1;
        wait_packets(3);
        check("cont_count", grant_hist.size(), 3);
        check("cont_first",  (grant_hist.size() > 0) ? grant_hist[0] : -1, 0);
        check("cont_second", (grant_hist.size() > 1) ? grant_hist[1] : -1, 1);
        check("cont_third",  (grant_hist.size() > 2) ? grant_hist[2] : -1, 0);

        // Packer backpressure every third cycle.
        bp = 1'b1;
        want[0] = 1'b1;
        wait_packets(1);
        bp = 1'b0;

        // src1 abandons after 100 bytes: 147 pad bytes follow.
        abandon_after[1] = 100;
        want[1] = 1'b1;
        wait_packets(1);
        abandon_after[1] = LB;

        // src0 withholds valid for 50 cycles with request held.
        stall_src = 0; stall_at = 60; stall_left = 50;
        want[0] = 1'b1;
        wait_packets(1);
        check("stall_consumed", stall_left, 0);

        // Asynchronous reset in the middle of LOAD.
        want[0] = 1'b1;
        packets_left = 1;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (sent[0] >= 20) break;
        end
        check("mid_load_reached", (sent[0] >= 20) ? 1 : 0, 1);
        @(posedge i_clk);
        #3;
        i_reset = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        model_reset();
        want[0] = 1'b0; want[1] = 1'b1;
        tick(); tick();
        i_reset = 1'b1;
        grant_hist.delete();
        wait_packets(1);
        check("after_rst_src", (grant_hist.size() > 0) ? grant_hist[0] : -1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
